// File: rtl/acq_sequencer.sv
// acq_sequencer: sequences ADC/AGC setup phases (clear, load, enable, timed run) and flags host blocks
module acq_sequencer #(
  parameter int NCH        = 2,
  parameter int CTRL_W     = 10,
  parameter int AGC_W      = 12,
  parameter int CNT_W      = 32,
  parameter int CLR_LEN    = 4,
  parameter int T_LDCTRL   = 100,
  parameter int T_ENABLE   = 1000,
  parameter int T_RUN      = 1000000000,
  parameter int WRCNT_W    = 12,
  parameter int WORD_BYTES = 4,
  parameter int BLOCKSIZE  = 4096
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_mode,
  input  logic [NCH-1:0]        ch_mask,
  input  logic [NCH*CTRL_W-1:0] ctrlword_cfg,
  input  logic [AGC_W-1:0]      agc_cfg,
  input  logic [WRCNT_W-1:0]    fifo_wrcnt,
  input  logic                  fifo_full,
  output logic [NCH-1:0]        adc_ldctrl,
  output logic [NCH*CTRL_W-1:0] adc_ctrlword,
  output logic [NCH-1:0]        adc_enable,
  output logic [AGC_W-1:0]      agc_data,
  output logic                  agc_load,
  output logic                  fifo_clr,
  output logic                  blk_rdy,
  output logic                  overflow,
  output logic                  busy,
  output logic [2:0]            state_o
);
  localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_SETUP = 3'd2, S_RUN = 3'd3, S_DONE = 3'd4;
  localparam logic [CNT_W-1:0] C_CLR = CNT_W'(CLR_LEN - 1);
  localparam logic [CNT_W-1:0] C_LD = CNT_W'(T_LDCTRL);
  localparam logic [CNT_W-1:0] C_EN = CNT_W'(T_ENABLE);
  localparam logic [CNT_W-1:0] C_END = CNT_W'(T_ENABLE + T_RUN);
  localparam int PW = WRCNT_W + $clog2(WORD_BYTES) + 1;
  localparam logic [PW-1:0] C_BS = PW'(BLOCKSIZE);
  localparam logic [PW-1:0] C_WB = PW'(WORD_BYTES);
  localparam logic [AGC_W-1:0] C_AGC_RST = AGC_W'(12'h333);
  logic [2:0] r_state, w_nstate;
  logic [CNT_W-1:0] r_timer, w_ntimer, w_tinc;
  logic [NCH-1:0] r_mask, r_ld, r_en, w_ld, w_en;
  logic [NCH*CTRL_W-1:0] r_ctrl;
  logic [AGC_W-1:0] r_agc;
  logic [PW-1:0] w_bytes;
  logic r_agc_ld, r_clr, r_blk, r_ovf, r_busy, w_agc_ld, w_clr, w_accept;
  assign w_accept = r_state == S_IDLE && start && !stop;
  assign w_tinc = &r_timer ? r_timer : r_timer + CNT_W'(1);
  assign w_bytes = PW'(fifo_wrcnt) * C_WB;
  assign adc_ldctrl = r_ld;
  assign adc_ctrlword = r_ctrl;
  assign adc_enable = r_en;
  assign agc_data = r_agc;
  assign agc_load = r_agc_ld;
  assign fifo_clr = r_clr;
  assign blk_rdy = r_blk;
  assign overflow = r_ovf;
  assign busy = r_busy;
  assign state_o = r_state;
  // State and phase timer; the timer doubles as the clear-length counter
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_nstate;
      r_timer <= w_ntimer;
    end
  end
  // Next state; stop overrides every other transition
  always_comb begin
    w_nstate = r_state;
    w_ntimer = w_tinc;
    case (r_state)
      S_IDLE: begin
        w_ntimer = '0;
        if (w_accept) w_nstate = S_CLEAR;
      end
      S_CLEAR: if (r_timer == C_CLR) begin
        w_nstate = S_SETUP;
        w_ntimer = '0;
      end
      S_SETUP: if (w_tinc == C_EN) w_nstate = S_RUN;
      S_RUN: if (T_RUN != 0 && w_tinc == C_END) w_nstate = S_DONE;
      S_DONE: begin
        w_nstate = loop_mode ? S_CLEAR : S_IDLE;
        w_ntimer = '0;
      end
      default: w_nstate = S_IDLE;
    endcase
    if (stop && r_state != S_IDLE) w_nstate = S_IDLE;
  end
  // Outputs decoded from the next state so the registered strobes line up with the state they belong to
  always_comb begin
    w_clr = w_nstate == S_CLEAR;
    w_ld = (w_nstate == S_SETUP && w_ntimer == C_LD) ? r_mask : '0;
    w_en = w_nstate == S_RUN ? r_mask : '0;
    w_agc_ld = w_nstate == S_RUN && r_state == S_SETUP;
  end
  // Output registers, latched config, sticky overflow and block-ready flag
  always_ff @(posedge clk) begin
    if (srst) begin
      r_ld <= '0;
      r_en <= '0;
      r_agc_ld <= 1'b0;
      r_clr <= 1'b0;
      r_blk <= 1'b0;
      r_ovf <= 1'b0;
      r_busy <= 1'b0;
      r_mask <= '0;
      r_ctrl <= '0;
      r_agc <= C_AGC_RST;
    end else begin
      r_ld <= w_ld;
      r_en <= w_en;
      r_agc_ld <= w_agc_ld;
      r_clr <= w_clr;
      r_busy <= w_nstate != S_IDLE;
      r_blk <= !w_clr && w_bytes >= C_BS;
      r_ovf <= w_accept ? 1'b0 : r_ovf | (r_state == S_RUN && fifo_full);
      if (w_accept) begin
        r_mask <= ch_mask;
        r_ctrl <= ctrlword_cfg;
        r_agc <= agc_cfg;
      end
    end
  end
endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: directed cycle-accurate checks of the acquisition sequencer
module tb_acq_sequencer;
  logic clk = 0, srst = 1, start = 0, stop = 0, loop_mode = 0, fifo_full = 0;
  logic [1:0] ch_mask = 0;
  logic [19:0] ctrlword_cfg = 0;
  logic [11:0] agc_cfg = 0;
  logic [11:0] fifo_wrcnt = 0;
  logic [1:0] adc_ldctrl, adc_enable;
  logic [19:0] adc_ctrlword;
  logic [11:0] agc_data;
  logic agc_load, fifo_clr, blk_rdy, overflow, busy;
  logic [2:0] state_o;
  int cyc, n_vec, n_err;
  acq_sequencer #(.NCH(2), .CLR_LEN(4), .T_LDCTRL(3), .T_ENABLE(10), .T_RUN(20)) dut (
    .clk(clk), .srst(srst), .start(start), .stop(stop), .loop_mode(loop_mode),
    .ch_mask(ch_mask), .ctrlword_cfg(ctrlword_cfg), .agc_cfg(agc_cfg),
    .fifo_wrcnt(fifo_wrcnt), .fifo_full(fifo_full),
    .adc_ldctrl(adc_ldctrl), .adc_ctrlword(adc_ctrlword), .adc_enable(adc_enable),
    .agc_data(agc_data), .agc_load(agc_load), .fifo_clr(fifo_clr), .blk_rdy(blk_rdy),
    .overflow(overflow), .busy(busy), .state_o(state_o)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic go();
    start = 1;
    cyc = 0;
    tick();
    start = 0;
  endtask
  function automatic logic [11:0] obs();
    return {state_o, busy, fifo_clr, adc_ldctrl, adc_enable, agc_load, overflow, blk_rdy};
  endfunction
  // Hand timeline for CLR_LEN=4, T_LDCTRL=3, T_ENABLE=10, T_RUN=20 with start at cycle 0
  function automatic logic [11:0] expv(int c, logic lp, logic [1:0] m, int ovf_from);
    int k;
    logic [2:0] s;
    logic clr;
    k = (lp && c >= 36) ? c - 35 : c;
    s = (k == 0) ? 3'd0 : (k <= 4) ? 3'd1 : (k <= 14) ? 3'd2 : (k <= 34) ? 3'd3 : (k == 35) ? 3'd4 : 3'd0;
    clr = s == 3'd1;
    return {s, s != 3'd0, clr, k == 8 ? m : 2'b00, s == 3'd3 ? m : 2'b00, k == 15, c >= ovf_from, !clr};
  endfunction
  initial begin
    tick();
    tick();
    srst = 0;
    tick();
    chk("reset_ctl", {32'b0, obs()}, 64'h0);
    chk("reset_agc", {52'b0, agc_data}, 64'h333);
    chk("reset_cw", {44'b0, adc_ctrlword}, 64'h0);
    fifo_wrcnt = 12'd1023;
    tick();
    chk("blk_1023", {63'b0, blk_rdy}, 64'h0);
    fifo_wrcnt = 12'd1024;
    tick();
    chk("blk_1024", {63'b0, blk_rdy}, 64'h1);
    ch_mask = 2'b11;
    ctrlword_cfg = {10'h155, 10'h0AA};
    agc_cfg = 12'hABC;
    go();
    for (int c = 1; c <= 36; c++) begin
      chk($sformatf("run1_c%0d", c), {52'b0, obs()}, {52'b0, expv(c, 1'b0, 2'b11, 21)});
      fifo_full = (c == 7 || c == 20);
      tick();
    end
    chk("run1_cw", {44'b0, adc_ctrlword}, {44'b0, 10'h155, 10'h0AA});
    chk("run1_agc", {52'b0, agc_data}, 64'hABC);
    ch_mask = 2'b10;
    loop_mode = 1;
    go();
    for (int c = 1; c <= 40; c++) begin
      chk($sformatf("run2_c%0d", c), {52'b0, obs()}, {52'b0, expv(c, 1'b1, 2'b10, 31)});
      ch_mask = (c >= 2) ? 2'b01 : 2'b10;
      ctrlword_cfg = (c >= 2) ? 20'h12345 : {10'h155, 10'h0AA};
      agc_cfg = (c >= 2) ? 12'h111 : 12'hABC;
      fifo_full = c == 30;
      start = c == 33;
      stop = c == 40;
      tick();
    end
    stop = 0;
    start = 0;
    for (int c = 41; c <= 46; c++) begin
      chk($sformatf("stop_c%0d", c), {55'b0, state_o, busy, adc_enable, adc_ldctrl, overflow},
          {55'b0, 3'd0, 1'b0, 2'b00, 2'b00, 1'b1});
      tick();
    end
    chk("run2_cw", {44'b0, adc_ctrlword}, {44'b0, 10'h155, 10'h0AA});
    chk("run2_agc", {52'b0, agc_data}, 64'hABC);
    loop_mode = 0;
    start = 1;
    stop = 1;
    tick();
    start = 0;
    stop = 0;
    chk("ss_same", {59'b0, state_o, busy, fifo_clr}, 64'h0);
    tick();
    chk("ss_same2", {59'b0, state_o, busy, fifo_clr}, 64'h0);
    ch_mask = 2'b11;
    go();
    chk("ovf_clr", {63'b0, overflow}, 64'h0);
    while (cyc < 14) tick();
    chk("pre_en", {52'b0, obs()}, {52'b0, expv(14, 1'b0, 2'b11, 99)});
    stop = 1;
    tick();
    stop = 0;
    for (int c = 15; c <= 18; c++) begin
      chk($sformatf("stop_en_c%0d", c), {58'b0, state_o, adc_enable, agc_load}, 64'h0);
      tick();
    end
    agc_cfg = 12'h5A5;
    ctrlword_cfg = 20'hFEDCB;
    go();
    while (cyc < 12) tick();
    chk("pre_rst", {61'b0, state_o}, 64'h2);
    srst = 1;
    tick();
    srst = 0;
    chk("rst_ctl", {32'b0, obs()}, 64'h0);
    chk("rst_agc", {52'b0, agc_data}, 64'h333);
    chk("rst_cw", {44'b0, adc_ctrlword}, 64'h0);
    tick();
    chk("post_rst", {32'b0, obs()}, 64'h1);
    chk("post_rst_cw", {44'b0, adc_ctrlword}, 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
